// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: next-PC/execute handshake, instruction memory port and status.
// master is the controller side; slave is the surrounding pipeline and memory.
interface pc_fetch_ctrl_if;
  logic [63:0] NextPC;
  logic        NextPCValid;
  logic        InstrReady;
  logic        Halt;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] RetiredCount;
  logic        Fault;

  modport master (
    input  NextPC, NextPCValid, InstrReady, Halt, IMemAck, IMemData,
    output CurrentPC, IMemReq, IMemAddr, Instruction, InstrValid, RetiredCount, Fault
  );

  modport slave (
    output NextPC, NextPCValid, InstrReady, Halt, IMemAck, IMemData,
    input  CurrentPC, IMemReq, IMemAddr, Instruction, InstrValid, RetiredCount, Fault
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: one fetch, then hold the word in EXEC until retire; ack-to-InstrValid 1 cycle.
// Execute backpressure (InstrReady/NextPCValid low) stalls EXEC; a fetch with no ack faults after TIMEOUT cycles.
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  pc_fetch_ctrl_if.master bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   retired_q, retired_d;
  logic [CW-1:0] wait_q, wait_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.IMemAck) begin
          instr_d = bus.IMemData;
          wait_d  = '0;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_MAX) begin
          // This edge closes the TIMEOUT-th unanswered request cycle.
          wait_d  = '0;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.InstrReady && bus.NextPCValid) begin
          pc_d      = bus.NextPC;
          retired_d = retired_q + 32'd1;
          if (bus.NextPC[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else if (bus.Halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign bus.CurrentPC    = pc_q;
  assign bus.IMemAddr     = pc_q;
  assign bus.IMemReq      = (state_q == S_FETCH);
  assign bus.Instruction  = instr_q;
  assign bus.InstrValid   = (state_q == S_EXEC);
  assign bus.RetiredCount = retired_q;
  assign bus.Fault        = (state_q == S_FAULT);

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning PC loaded on reset; it must be a multiple of 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of consecutive cycles IMemReq may wait without IMemAck.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port NextPC  input  64  next-PC value from the next-PC logic.
REQ-006 The block SHALL have port NextPCValid  input  1  NextPC has settled for the current instruction.
REQ-007 The block SHALL have port InstrReady  input  1  execute stage consumes Instruction this cycle.
REQ-008 The block SHALL have port Halt  input  1  stop at the next instruction boundary.
REQ-009 The block SHALL have port IMemAck  input  1  instruction memory returns IMemData this cycle.
REQ-010 The block SHALL have port IMemData  input  32  instruction word from memory.
REQ-011 The block SHALL have port CurrentPC  output  64  architectural PC, fed to the next-PC logic.
REQ-012 The block SHALL have port IMemReq  output  1  instruction fetch request.
REQ-013 The block SHALL have port IMemAddr  output  64  fetch address; equals CurrentPC.
REQ-014 The block SHALL have port Instruction  output  32  latched instruction word.
REQ-015 The block SHALL have port InstrValid  output  1  Instruction is valid for execute.
REQ-016 The block SHALL have port RetiredCount  output  32  count of retired instructions.
REQ-017 The block SHALL have port Fault  output  1  sticky fetch fault (misaligned PC or memory timeout).

Function
REQ-018 The FSM SHALL have states RESET, FETCH, EXEC, HALTED and FAULT; all outputs are Moore outputs of state and registers.
REQ-019 From RESET, the FSM SHALL go to FETCH unconditionally on the next edge.
REQ-020 In FETCH, the block SHALL hold IMemReq=1 and IMemAddr=CurrentPC constant until IMemAck.
REQ-021 In FETCH with IMemAck=1, the block SHALL capture IMemData into Instruction, set InstrValid=1, clear the wait counter and go to EXEC; ack-to-InstrValid latency is 1 cycle.
REQ-022 In FETCH with IMemAck=0, the block SHALL increment the wait counter; when the counter reaches TIMEOUT-1 with no ack, the FSM SHALL go to FAULT on that edge, so FAULT is entered after exactly TIMEOUT request cycles without ack.
REQ-023 IMemAck SHALL be ignored in every state other than FETCH.
REQ-024 In EXEC, the block SHALL hold Instruction and InstrValid=1 stable while InstrReady=0 or NextPCValid=0.
REQ-025 In EXEC with InstrReady=1 and NextPCValid=1 (retire), the block SHALL load CurrentPC<=NextPC, clear InstrValid, and increment RetiredCount modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-026 On retire with NextPC[1:0]!=0, the FSM SHALL go to FAULT with CurrentPC still loaded with NextPC; this check takes priority over Halt.
REQ-027 On retire with NextPC[1:0]==0 and Halt=1, the FSM SHALL go to HALTED; otherwise it SHALL go to FETCH.
REQ-028 Halt asserted outside a retire cycle SHALL have no effect.
REQ-029 Minimum instruction period SHALL be 2 cycles: a FETCH cycle with ack, then an EXEC cycle with retire.
REQ-030 In HALTED, the block SHALL hold IMemReq=0 and InstrValid=0 and freeze CurrentPC and RetiredCount until Reset.
REQ-031 In FAULT, the block SHALL hold Fault=1, IMemReq=0 and InstrValid=0, and freeze CurrentPC and RetiredCount until Reset.

Reset
REQ-032 Reset SHALL have priority over all inputs and take effect at the next rising edge from any state.
REQ-033 On Reset, the block SHALL set state=RESET, CurrentPC=RESET_PC, IMemReq=0, Instruction=0, InstrValid=0, RetiredCount=0, Fault=0 and wait counter=0.
REQ-034 Reset asserted mid-fetch SHALL drop IMemReq at that edge, and an IMemAck arriving afterward (state RESET) SHALL be ignored.

Verification
REQ-035 The bench SHALL cover: Reset released, RESET_PC=0, IMemAck with 0xF8000000 on the first FETCH cycle -> IMemReq=1 in cycle 1; InstrValid=1 and Instruction=0xF8000000 in cycle 2.
REQ-036 The bench SHALL cover: EXEC with InstrReady=1 and NextPCValid=0 for 3 cycles, then NextPCValid=1 with NextPC=0x40 -> InstrValid stays 1 for 3 cycles; then CurrentPC=0x40, RetiredCount=1, IMemAddr=0x40.
REQ-037 The bench SHALL cover: TIMEOUT=16 with IMemAck held low -> IMemReq high for exactly 16 cycles, then Fault=1 and IMemReq=0 until Reset.
REQ-038 The bench SHALL cover: retire with NextPC=0x42 and Halt=1 -> FAULT, CurrentPC=0x42, Fault=1 (misalignment beats Halt).
REQ-039 The bench SHALL cover: retire with Halt=1 and NextPC=0x10 -> HALTED, CurrentPC=0x10, IMemReq stays 0; a subsequent Reset -> CurrentPC=RESET_PC and RetiredCount=0.
REQ-040 The bench SHALL cover: RetiredCount forced to 0xFFFFFFFF, one retire -> RetiredCount=0; Reset asserted during FETCH with IMemAck one cycle later -> Instruction remains 0 and InstrValid remains 0.
